// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, state encoding and arctangent table for the
// polar<->rectangular conversion paths.
package cordic_pkg;

  localparam logic [15:0] K_INV     = 16'd39797;  // round(0.607253 * 2^16)
  localparam int          ANGLE_90  = 92160;
  localparam int          ANGLE_180 = 184320;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_DONE
  } state_t;

  // round(atan(2^-i) * 180/pi * 1024); entries past the table end read as 0
  function automatic int atan_lookup(input int i);
    case (i)
      0:       return 46080;
      1:       return 27203;
      2:       return 14373;
      3:       return 7296;
      4:       return 3662;
      5:       return 1833;
      6:       return 917;
      7:       return 458;
      8:       return 229;
      9:       return 115;
      10:      return 57;
      11:      return 29;
      12:      return 14;
      13:      return 7;
      14:      return 4;
      15:      return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, shared by both conversion directions.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int COUNTERSIZE = 4,
  parameter int OUTSIZE     = 19
) (
  input  logic [COUNTERSIZE-1:0]    index,
  output logic signed [OUTSIZE-1:0] value
);

  always_comb begin
    value = OUTSIZE'(atan_lookup(int'(index)));
  end

endmodule

// File: rtl/polar2rect.sv
// Sequential rotation-mode CORDIC: (mod, angle in degrees*1024) -> (x, y),
// one micro-rotation per clock with a start/busy/done handshake.
module polar2rect
  import cordic_pkg::*;
#(
  parameter int ROMSIZE     = 16,
  parameter int COUNTERSIZE = 4,
  parameter int INSIZE      = 13,
  parameter int OUTSIZE     = 19,
  parameter int GUARD       = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic [INSIZE-2:0]         mod,
  input  logic signed [OUTSIZE-1:0] angle,
  output logic signed [INSIZE-1:0]  x,
  output logic signed [INSIZE-1:0]  y
);

  localparam int W  = INSIZE + GUARD;
  localparam int ZW = OUTSIZE + 1;

  localparam logic signed [ZW-1:0] A90    = ZW'(ANGLE_90);
  localparam logic signed [ZW-1:0] A180   = ZW'(ANGLE_180);
  localparam logic signed [W-1:0]  SAT_HI = W'((1 << (INSIZE - 1)) - 1);
  localparam logic signed [W-1:0]  SAT_LO = -SAT_HI - W'(1);

  state_t                    state, state_next;
  logic [COUNTERSIZE-1:0]    iter;
  logic [INSIZE-2:0]         mod_cap;
  logic signed [OUTSIZE-1:0] angle_cap;
  logic signed [W-1:0]       xr, yr;
  logic signed [ZW-1:0]      z;
  logic                      neg;

  logic signed [OUTSIZE-1:0] atan_val;
  logic signed [ZW-1:0]      atan_ext, a_ext, a_clamp, z_fold;
  logic                      neg_fold, accept;
  logic [INSIZE+14:0]        prod;
  logic signed [W-1:0]       x_shift, y_shift, x_fin, y_fin, x_sat, y_sat;

  cordic_atan_rom #(
    .COUNTERSIZE(COUNTERSIZE),
    .OUTSIZE    (OUTSIZE)
  ) u_atan_rom (
    .index(iter),
    .value(atan_val)
  );

  // A new request is taken in IDLE and also in the DONE cycle, so conversions
  // can run back to back every ROMSIZE+2 clocks.
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_ITER;
      ST_ITER: if (iter == COUNTERSIZE'(ROMSIZE - 1)) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Clamp then fold into [-90, +90] degrees; the fold is undone by negation.
  always_comb begin
    a_ext    = ZW'(angle_cap);
    a_clamp  = a_ext;
    if (a_ext > A180)       a_clamp = A180;
    else if (a_ext < -A180) a_clamp = -A180;
    z_fold   = a_clamp;
    neg_fold = 1'b0;
    if (a_clamp > A90) begin
      z_fold   = a_clamp - A180;
      neg_fold = 1'b1;
    end else if (a_clamp < -A90) begin
      z_fold   = a_clamp + A180;
      neg_fold = 1'b1;
    end
  end

  always_comb begin
    prod     = (INSIZE + 15)'(mod_cap) * (INSIZE + 15)'(K_INV);
    atan_ext = ZW'(atan_val);
    x_shift  = xr >>> iter;
    y_shift  = yr >>> iter;
    x_fin    = neg ? -xr : xr;
    y_fin    = neg ? -yr : yr;
    x_sat    = (x_fin > SAT_HI) ? SAT_HI : ((x_fin < SAT_LO) ? SAT_LO : x_fin);
    y_sat    = (y_fin > SAT_HI) ? SAT_HI : ((y_fin < SAT_LO) ? SAT_LO : y_fin);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      iter      <= '0;
      mod_cap   <= '0;
      angle_cap <= '0;
      xr        <= '0;
      yr        <= '0;
      z         <= '0;
      neg       <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else begin
      done <= (state == ST_DONE);
      if (accept) begin
        mod_cap   <= mod;
        angle_cap <= angle;
      end
      case (state)
        ST_LOAD: begin
          xr   <= W'(prod >> 16);
          yr   <= '0;
          z    <= z_fold;
          neg  <= neg_fold;
          iter <= '0;
        end
        ST_ITER: begin
          iter <= iter + 1'b1;
          if (!z[ZW-1]) begin
            xr <= xr - y_shift;
            yr <= yr + x_shift;
            z  <= z - atan_ext;
          end else begin
            xr <= xr + y_shift;
            yr <= yr - x_shift;
            z  <= z + atan_ext;
          end
        end
        ST_DONE: begin
          x <= INSIZE'(x_sat);
          y <= INSIZE'(y_sat);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar2rect.sv
// Directed-vector bench for polar2rect: table of conversions with expected
// trigonometric results, plus handshake and mid-conversion reset sequences.
module tb_polar2rect;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               busy, done;
  logic [11:0]        mod   = '0;
  logic signed [18:0] angle = '0;
  logic signed [12:0] x, y;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  polar2rect dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .busy (busy),
    .done (done),
    .mod  (mod),
    .angle(angle),
    .x    (x),
    .y    (y)
  );

  always #5 clock = ~clock;

  // done is a full-cycle pulse, so one falling-edge sample per pulse
  always @(negedge clock) if (done) done_count++;

  typedef struct {
    int m;
    int a;
    int ex;
    int ey;
    int tol;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Leaves the bench #1 after edge n, the edge at which start is sampled.
  task automatic start_conv(input int m, input int a);
    @(negedge clock);
    mod   = m[11:0];
    angle = a[18:0];
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after edge n until done is seen; bounded.
  task automatic wait_done(output int lat);
    bit got;
    lat = 0;
    got = 0;
    while (!got && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
      if (lat == 1 && !busy) begin
        errors++;
        checks++;
        $display("FAIL busy_rise: got 0, expected 1");
      end
      if (done) got = 1;
    end
  endtask

  initial begin
    int lat;
    int dc0;

    vecs[0]  = '{1000,       0,  1000,     0, 8};
    vecs[1]  = '{1000,   92160,     0,  1000, 8};
    vecs[2]  = '{1000,  -92160,     0, -1000, 8};
    vecs[3]  = '{2000,  138240, -1414,  1414, 8};
    vecs[4]  = '{3000,   46080,  2121,  2121, 8};
    vecs[5]  = '{2000,  -30720,  1732, -1000, 8};
    vecs[6]  = '{1000,  153600,  -866,   500, 8};
    vecs[7]  = '{1500, -122880,  -750, -1299, 8};
    vecs[8]  = '{4095, -184320, -4095,     0, 8};
    vecs[9]  = '{4095,  184320, -4095,     0, 8};
    vecs[10] = '{2500,  262143, -2500,     0, 8};
    vecs[11] = '{2500, -262144, -2500,     0, 8};
    vecs[12] = '{   0,   61440,     0,     0, 0};

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", int'(busy), 0, 0);
    check("reset_done", int'(done), 0, 0);
    check("reset_x", int'(x), 0, 0);
    check("reset_y", int'(y), 0, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 13; i++) begin
      start_conv(vecs[i].m, vecs[i].a);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, 18, 0);
      check($sformatf("v%0d_x", i), int'(x), vecs[i].ex, vecs[i].tol);
      check($sformatf("v%0d_y", i), int'(y), vecs[i].ey, vecs[i].tol);
      check($sformatf("v%0d_busy_low", i), int'(busy), 0, 0);
      $display("vec %0d: mod=%0d angle=%0d -> x=%0d y=%0d lat=%0d",
               i, vecs[i].m, vecs[i].a, x, y, lat);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_done_pulse", i), int'(done), 0, 0);
    end

    // Second start at cycle +5 with very different inputs must be ignored.
    dc0 = done_count;
    start_conv(1000, 46080);
    repeat (4) @(posedge clock);
    @(negedge clock);
    mod   = 12'd4000;
    angle = -19'sd92160;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("hs_latency", lat, 18, 0);
    check("hs_x", int'(x), 707, 8);
    check("hs_y", int'(y), 707, 8);
    repeat (25) @(posedge clock);
    #1;
    check("hs_done_count", done_count - dc0, 1, 0);
    check("hs_x_hold", int'(x), 707, 8);
    $display("handshake: x=%0d y=%0d done_pulses=%0d", x, y, done_count - dc0);

    // Reset asserted for the edge at cycle +8 of a conversion.
    start_conv(2000, 0);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_x", int'(x), 0, 0);
    check("rst_y", int'(y), 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_stays_idle", int'(busy), 0, 0);
    start_conv(1000, 92160);
    wait_done(lat);
    check("post_rst_latency", lat, 18, 0);
    check("post_rst_x", int'(x), 0, 8);
    check("post_rst_y", int'(y), 1000, 8);
    $display("reset recovery: x=%0d y=%0d lat=%0d", x, y, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
